// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter and its rotating-priority picker.
// State encoding is kept as plain 1-bit constants so legacy code can compare against them.
package fifo_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        XFER = ST_XFER
    } arb_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int calc_id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority selector: returns the first set request at or above i_start, wrapping modulo N.
// Purely combinational, zero latency; no handshake of its own.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    int w_cand;

    // Walk offsets from highest to lowest so the smallest offset from i_start wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = int'(i_start) + i;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the async FIFO write port; grant 1 cycle after request.
// Beats accepted only while wfull_i is low; a full FIFO stalls the holder indefinitely, no timeout.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int ID_WIDTH   = calc_id_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    input  logic                          wfull_i,
    output logic [NUM_REQ-1:0]            ready_o,
    output logic                          wr_en_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    output logic [ID_WIDTH-1:0]           gnt_id_o,
    output logic                          busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e          r_state;
    logic [ID_WIDTH-1:0] r_rr_ptr;
    logic [ID_WIDTH-1:0] r_gnt_id;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic                w_found;
    logic [ID_WIDTH-1:0] w_pick;
    logic                w_busy;
    logic                w_req_g;
    logic                w_last_g;
    logic                w_beat;
    logic                w_cap;
    logic                w_release;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_WIDTH)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_start (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_busy   = (r_state == XFER);
    assign w_req_g  = req_i[r_gnt_id];
    assign w_last_g = last_i[r_gnt_id];
    assign w_beat   = w_busy & w_req_g & ~wfull_i;
    assign w_cap    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    // A withdrawn request releases without writing; full never releases.
    assign w_release = w_busy & ((w_beat & (w_last_g | w_cap)) | ~w_req_g);

    always_comb begin
        ready_o = '0;
        if (w_busy && !wfull_i) begin
            ready_o[r_gnt_id] = 1'b1;
        end
    end

    assign wr_en_o   = w_beat;
    assign wr_data_o = w_busy ? data_i[int'(r_gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign gnt_id_o  = r_gnt_id;
    assign busy_o    = w_busy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_gnt_id   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt_id   <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                default: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_release) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= (r_gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
